hazard_ctrl_seq: RTL and testbench
==================================

Name: hazard_ctrl_seq

Overview:
Sequential, parametrised successor to the ID-stage stall/bubble controller. It generates per-pipeline-register bubble and write-enable vectors plus the PC write enable for an N-stage in-order RISC-V pipeline. Multi-cycle hazards are tracked in a registered FSM rather than re-derived every cycle: configurable load-use latency, memory-wait freeze with resume, and trap hold until in-flight branches resolve. It sits beside the ID stage and drives every pipeline register and the PC.

Parameters:
NUM_STAGES, 5, pipeline stages; NREG = NUM_STAGES-1 pipeline registers, index 0 = IF/ID, index 1 = ID/EX, up to NREG-1 = last (MEM/WB at default)
REG_ADDR_W, 5, register-index width
LOAD_USE_LAT, 1, stall cycles inserted per load-use hazard (range 1..15)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
instr_stall  in  1  instruction fetch not ready
ifid_rs1, ifid_rs2  in  REG_ADDR_W  source registers in ID
idex_rd  in  REG_ADDR_W  destination register in EX
idex_memread, idex_memwrite  in  1  EX instruction is load / store
mem_read  in  1  ID instruction is a load (structural check)
mem_ready  in  1  data memory ready
jump  in  1  jump in ID
branch_pending  in  2  bit0 = branch in ID/EX, bit1 = branch in EX/MEM
syscall, int_trap, trap_in_id, flush_pipeline, pc_src  in  1  same meaning as the existing stall unit
bubble  out  NREG  per-register bubble insert
write_en  out  NREG  per-register write enable
write_pc  out  1  PC write enable
trap_waiting  out  1  trap may be taken this cycle
state_o  out  2  current FSM state (debug)

Behaviour:
- FSM states: RUN=0, LOAD_STALL=1, MEM_WAIT=2, TRAP_HOLD=3. Registers: state, resume_state (2b), cnt (4b).
- Reset (reset=1 at a clk edge): state=RUN, resume_state=RUN, cnt=0. While reset is high: bubble = all 1, write_en = all 1, write_pc=0, trap_waiting=0.
- Outputs are combinational from state and inputs. Defaults: bubble=0, write_en=all 1, write_pc=1, trap_waiting=syscall.
- "Hold front" means: bubble[1]=1, write_en[0]=0, write_pc=0, trap_waiting=0.
- Output priority, highest first:
  1. mem_ready=0: write_en=0, write_pc=0, trap_waiting=0. If state is not MEM_WAIT, set resume_state=state and next state=MEM_WAIT. cnt is frozen.
  2. MEM_WAIT with mem_ready=1: next state=resume_state. Outputs for that cycle are evaluated as if in resume_state.
  3. LOAD_STALL: hold front. cnt decrements; when cnt reaches 1, next state=RUN.
  4. TRAP_HOLD: bubble[1]=1, write_en[0]=0, trap_waiting=0, write_pc=1. When branch_pending==0, next state=RUN.
  5. RUN, branch_pending!=0 and syscall=1: same outputs as TRAP_HOLD; next state=TRAP_HOLD.
  6. RUN, mem_read and idex_memwrite: hold front for 1 cycle; state stays RUN.
  7. RUN, load-use: idex_memread=1, idex_rd!=0, and idex_rd equals ifid_rs1 or ifid_rs2. Hold front. If LOAD_USE_LAT>1: cnt=LOAD_USE_LAT-1, next state=LOAD_STALL. x0 never stalls.
  8. RUN, (jump and not instr_stall) or trap_in_id: bubble[0]=1.
- instr_stall=1 (applied after rules 3–8): write_pc=0; additionally, if jump=1, write_en[0]=0.
- int_trap=1 overrides all of the above: bubble = all 1, write_pc=1, next state=RUN, cnt=0.
- Else pc_src=1 overrides all of the above: bubble[NREG-2:0]=all 1, write_pc=1, next state=RUN, cnt=0. This cancels any LOAD_STALL or TRAP_HOLD.
- flush_pipeline=1: bubble[0]=1, OR-ed in last.
- Total load-use stall is exactly LOAD_USE_LAT cycles, not counting MEM_WAIT cycles.
- A reset asserted mid-stall returns the FSM to RUN on the next edge.

Optional Feature:
STALL_PERF_CNT_EN. When defined, adds outputs perf_load_stalls[31:0], perf_mem_stalls[31:0] and perf_trap_holds[31:0]. Each counts cycles spent in hold front due to load-use, with mem_ready=0, and in TRAP_HOLD (including the entry cycle), respectively. Counters wrap at 2^32 and clear on reset. When not defined, these ports and counters are absent and the block is otherwise identical.

Test Plan:
1. LOAD_USE_LAT=3; idex_memread=1, idex_rd=5, ifid_rs1=5 -> write_pc=0 and bubble[1]=1 for exactly 3 cycles, then write_pc=1.
2. Load-use with idex_rd=0, ifid_rs1=0 -> no stall; write_pc=1, bubble=0.
3. LOAD_USE_LAT=3; mem_ready=0 for 4 cycles during the 2nd stall cycle -> write_en=0 for those 4 cycles; after mem_ready=1, exactly 2 more stall cycles (3 total).
4. syscall=1 with branch_pending=2'b01 for 2 cycles -> state_o=3, trap_waiting=0; when branch_pending returns to 0 -> state_o=0, trap_waiting=1.
5. pc_src=1 during LOAD_STALL -> bubble[NREG-2:0]=all 1, write_pc=1, state_o=0 next cycle.
6. Assert reset in MEM_WAIT -> next cycle state_o=0; while reset is high, write_pc=0 and bubble=all 1.

Source files
------------

// File: rtl/hazard_ctrl_seq.sv
// hazard_ctrl_seq: sequential ID-stage stall/bubble controller for an N-stage in-order pipeline.
// Define STALL_PERF_CNT_EN to add load/mem/trap stall performance counters.
module hazard_ctrl_seq #(
  parameter int NUM_STAGES = 5,
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_USE_LAT = 1,
  localparam int NREG = NUM_STAGES - 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_stall,
  input  logic [REG_ADDR_W-1:0] ifid_rs1,
  input  logic [REG_ADDR_W-1:0] ifid_rs2,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic                  idex_memread,
  input  logic                  idex_memwrite,
  input  logic                  mem_read,
  input  logic                  mem_ready,
  input  logic                  jump,
  input  logic [1:0]            branch_pending,
  input  logic                  syscall,
  input  logic                  int_trap,
  input  logic                  trap_in_id,
  input  logic                  flush_pipeline,
  input  logic                  pc_src,
`ifdef STALL_PERF_CNT_EN
  output logic [31:0]           perf_load_stalls,
  output logic [31:0]           perf_mem_stalls,
  output logic [31:0]           perf_trap_holds,
`endif
  output logic [NREG-1:0]       bubble,
  output logic [NREG-1:0]       write_en,
  output logic                  write_pc,
  output logic                  trap_waiting,
  output logic [1:0]            state_o
);
  typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT, TRAP_HOLD} state_t;
  state_t state, resume_state, eff, nstate, nresume;
  logic [3:0] cnt, ncnt;
  logic load_use, lu_hold, sh_hold, trap_cyc;
  assign state_o = state;
  assign load_use = idex_memread && idex_rd != '0 && (idex_rd == ifid_rs1 || idex_rd == ifid_rs2);
  always_comb begin
    eff = (state == MEM_WAIT && mem_ready) ? resume_state : state;
    nstate = eff;
    nresume = resume_state;
    ncnt = cnt;
    bubble = '0;
    write_en = '1;
    write_pc = 1'b1;
    trap_waiting = syscall;
    lu_hold = 1'b0;
    sh_hold = 1'b0;
    trap_cyc = 1'b0;
    if (!mem_ready) begin
      write_en = '0;
      write_pc = 1'b0;
      trap_waiting = 1'b0;
      if (state != MEM_WAIT) begin
        nresume = state;
        nstate = MEM_WAIT;
      end
    end else if (eff == LOAD_STALL) begin
      lu_hold = 1'b1;
      ncnt = cnt - 4'd1;
      nstate = (cnt <= 4'd1) ? RUN : LOAD_STALL;
    end else if (eff == TRAP_HOLD) begin
      trap_cyc = 1'b1;
      nstate = (branch_pending == 2'b00) ? RUN : TRAP_HOLD;
    end else if (branch_pending != 2'b00 && syscall) begin
      trap_cyc = 1'b1;
      nstate = TRAP_HOLD;
    end else if (mem_read && idex_memwrite) begin
      sh_hold = 1'b1;
    end else if (load_use) begin
      lu_hold = 1'b1;
      if (LOAD_USE_LAT > 1) begin
        ncnt = 4'(LOAD_USE_LAT - 1);
        nstate = LOAD_STALL;
      end
    end else if ((jump && !instr_stall) || trap_in_id) begin
      bubble[0] = 1'b1;
    end
    if (lu_hold || sh_hold) begin
      bubble[1] = 1'b1;
      write_en[0] = 1'b0;
      write_pc = 1'b0;
      trap_waiting = 1'b0;
    end
    if (trap_cyc) begin
      bubble[1] = 1'b1;
      write_en[0] = 1'b0;
      trap_waiting = 1'b0;
    end
    if (instr_stall) begin
      write_pc = 1'b0;
      if (jump) write_en[0] = 1'b0;
    end
    // Redirects cancel any pending load stall or trap hold.
    if (int_trap) begin
      bubble = '1;
      write_pc = 1'b1;
      nstate = RUN;
      ncnt = '0;
    end else if (pc_src) begin
      bubble[NREG-2:0] = '1;
      write_pc = 1'b1;
      nstate = RUN;
      ncnt = '0;
    end
    if (flush_pipeline) bubble[0] = 1'b1;
    if (reset) begin
      bubble = '1;
      write_en = '1;
      write_pc = 1'b0;
      trap_waiting = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      resume_state <= RUN;
      cnt <= '0;
    end else begin
      state <= nstate;
      resume_state <= nresume;
      cnt <= ncnt;
    end
  end
`ifdef STALL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_load_stalls <= '0;
      perf_mem_stalls <= '0;
      perf_trap_holds <= '0;
    end else begin
      if (lu_hold && !int_trap && !pc_src) perf_load_stalls <= perf_load_stalls + 32'd1;
      if (!mem_ready) perf_mem_stalls <= perf_mem_stalls + 32'd1;
      if (trap_cyc && !int_trap && !pc_src) perf_trap_holds <= perf_trap_holds + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_hazard_ctrl_seq.sv
// tb_hazard_ctrl_seq: scoreboard bench for hazard_ctrl_seq with directed and random stimulus.
module tb_hazard_ctrl_seq;
  localparam int NS = 5;
  localparam int AW = 5;
  localparam int LAT = 3;
  localparam int NR = NS - 1;
  logic clk = 1'b0;
  logic reset, instr_stall, idex_memread, idex_memwrite, mem_read, mem_ready, jump;
  logic syscall, int_trap, trap_in_id, flush_pipeline, pc_src;
  logic [AW-1:0] ifid_rs1, ifid_rs2, idex_rd;
  logic [1:0] branch_pending, state_o;
  logic [NR-1:0] bubble, write_en;
  logic write_pc, trap_waiting;
  typedef struct packed {
    logic [NR-1:0] b;
    logic [NR-1:0] we;
    logic pc;
    logic tw;
    logic [1:0] st;
  } exp_t;
  exp_t q[$];
  string tq[$];
  int total = 0;
  int bad = 0;
  int owed = 0;
  bit in_trap = 0;
  bit mem_wait = 0;
  hazard_ctrl_seq #(.NUM_STAGES(NS), .REG_ADDR_W(AW), .LOAD_USE_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .instr_stall(instr_stall), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .idex_rd(idex_rd), .idex_memread(idex_memread), .idex_memwrite(idex_memwrite), .mem_read(mem_read),
    .mem_ready(mem_ready), .jump(jump), .branch_pending(branch_pending), .syscall(syscall),
    .int_trap(int_trap), .trap_in_id(trap_in_id), .flush_pipeline(flush_pipeline), .pc_src(pc_src),
    .bubble(bubble), .write_en(write_en), .write_pc(write_pc), .trap_waiting(trap_waiting), .state_o(state_o)
  );
  always #5 clk = ~clk;
  task automatic idle();
    reset = 0; instr_stall = 0; idex_memread = 0; idex_memwrite = 0; mem_read = 0; mem_ready = 1;
    jump = 0; syscall = 0; int_trap = 0; trap_in_id = 0; flush_pipeline = 0; pc_src = 0;
    ifid_rs1 = 0; ifid_rs2 = 0; idex_rd = 0; branch_pending = 0;
  endtask
  // Reference: 'owed' load-stall cycles still due, a pending trap flag, and whether memory froze us last cycle.
  task automatic step(input string tag);
    exp_t e;
    logic [NR-1:0] b, we, low;
    logic pc, tw;
    bit hold, th, lu;
    low = NR'((1 << (NR - 1)) - 1);
    e.st = mem_wait ? 2'd2 : owed > 0 ? 2'd1 : in_trap ? 2'd3 : 2'd0;
    b = '0; we = '1; pc = 1; tw = syscall; hold = 0; th = 0;
    lu = idex_memread && idex_rd != 0 && (idex_rd == ifid_rs1 || idex_rd == ifid_rs2);
    if (!mem_ready) begin
      we = '0; pc = 0; tw = 0; mem_wait = 1;
    end else begin
      mem_wait = 0;
      if (owed > 0) begin hold = 1; owed--; end
      else if (in_trap) begin th = 1; in_trap = branch_pending != 0; end
      else if (branch_pending != 0 && syscall) begin th = 1; in_trap = 1; end
      else if (mem_read && idex_memwrite) hold = 1;
      else if (lu) begin hold = 1; owed = LAT - 1; end
      else if ((jump && !instr_stall) || trap_in_id) b[0] = 1;
    end
    if (hold) begin b[1] = 1; we[0] = 0; pc = 0; tw = 0; end
    if (th) begin b[1] = 1; we[0] = 0; tw = 0; end
    if (instr_stall) begin pc = 0; if (jump) we[0] = 0; end
    if (int_trap || pc_src) begin
      b = int_trap ? '1 : (b | low); pc = 1; owed = 0; in_trap = 0; mem_wait = 0;
    end
    if (flush_pipeline) b[0] = 1;
    if (reset) begin b = '1; we = '1; pc = 0; tw = 0; owed = 0; in_trap = 0; mem_wait = 0; end
    e.b = b; e.we = we; e.pc = pc; e.tw = tw;
    q.push_back(e);
    tq.push_back(tag);
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e, g;
      string t;
      e = q.pop_front();
      t = tq.pop_front();
      g = {bubble, write_en, write_pc, trap_waiting, state_o};
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL %s t=%0t got b=%b we=%b pc=%b tw=%b st=%0d want b=%b we=%b pc=%b tw=%b st=%0d",
                 t, $time, g.b, g.we, g.pc, g.tw, g.st, e.b, e.we, e.pc, e.tw, e.st);
      end
    end
  end
  initial begin
    idle();
    reset = 1;
    @(posedge clk);
    #1;
    step("reset");
    reset = 0;
    step("idle");
    idex_memread = 1; idex_rd = 5; ifid_rs1 = 5;
    step("lu_entry");
    idle();
    repeat (3) step("lu_tail");
    idex_memread = 1; idex_rd = 0; ifid_rs1 = 0;
    step("x0_nostall");
    idle();
    idex_memread = 1; idex_rd = 7; ifid_rs2 = 7;
    step("lu2_entry");
    idle();
    mem_ready = 0;
    repeat (4) step("memwait");
    mem_ready = 1;
    repeat (3) step("lu2_resume");
    syscall = 1; branch_pending = 2'b01;
    repeat (2) step("trap_hold");
    branch_pending = 2'b00;
    repeat (2) step("trap_release");
    idle();
    idex_memread = 1; idex_rd = 3; ifid_rs1 = 3;
    step("lu3_entry");
    idle();
    step("lu3_stall");
    pc_src = 1;
    step("pc_src_cancel");
    pc_src = 0;
    step("after_cancel");
    mem_read = 1; idex_memwrite = 1;
    step("struct_hold");
    idle();
    jump = 1;
    step("jump");
    instr_stall = 1;
    step("jump_istall");
    idle();
    mem_ready = 0;
    repeat (2) step("mw_pre_reset");
    reset = 1;
    repeat (2) step("reset_in_mw");
    reset = 0; mem_ready = 1;
    step("post_reset");
    for (int i = 0; i < 600; i++) begin
      reset = $urandom_range(0, 59) == 0;
      instr_stall = $urandom_range(0, 5) == 0;
      idex_memread = $urandom_range(0, 1) == 1;
      idex_memwrite = $urandom_range(0, 3) == 0;
      mem_read = $urandom_range(0, 3) == 0;
      mem_ready = $urandom_range(0, 6) != 0;
      jump = $urandom_range(0, 4) == 0;
      syscall = $urandom_range(0, 3) == 0;
      int_trap = $urandom_range(0, 49) == 0;
      trap_in_id = $urandom_range(0, 9) == 0;
      flush_pipeline = $urandom_range(0, 9) == 0;
      pc_src = $urandom_range(0, 24) == 0;
      ifid_rs1 = AW'($urandom_range(0, 3));
      ifid_rs2 = AW'($urandom_range(0, 3));
      idex_rd = AW'($urandom_range(0, 3));
      branch_pending = 2'($urandom_range(0, 3));
      step("random");
    end
    idle();
    repeat (2) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain left=%0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
